// File: rtl/spi_pkg.sv
// Shared SPI definitions: default frame width and the sequencer state encoding.
package spi_pkg;

    localparam int unsigned SPI_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } seq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; DEPTH must be a power of two, at least 2.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the addresses match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                     (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];

    // Storage write.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
        end
    end

    // Pointer update; natural binary wrap gives modulo-DEPTH addressing.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/spi_frame_sequencer.sv
// Host-side SPI frame sequencer: TX/RX queues, frame FSM and sclk generator.
module spi_frame_sequencer
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SPI_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned HALF_DIV   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_ready,
    output logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_ready,
    output logic                  busy,
    output logic                  spi_enable,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic                  sclk_in,
    output logic                  positive_edge,
    output logic                  negative_edge,
    input  logic                  cs,
    input  logic [DATA_WIDTH-1:0] data_out
);

    localparam int unsigned      CNT_W    = $clog2(HALF_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_DIV - 1);

    seq_state_t            state;
    seq_state_t            next_state;
    logic                  tx_full;
    logic                  tx_empty;
    logic                  rx_full;
    logic                  rx_empty;
    logic [DATA_WIDTH-1:0] tx_head;
    logic [DATA_WIDTH-1:0] capture_reg;
    logic                  tx_push;
    logic                  rx_pop;
    logic                  frame_start;
    logic                  frame_end;
    logic                  cs_q;
    logic                  cs_rise;
    logic                  sclk_run;
    logic [CNT_W-1:0]      div_cnt;

    assign tx_ready = !tx_full;
    assign rx_valid = !rx_empty;
    assign tx_push  = tx_valid && tx_ready;
    assign rx_pop   = rx_valid && rx_ready;
    assign cs_rise  = cs && !cs_q;
    // Generator stops in the very cycle the chip select is released.
    assign sclk_run = (state == RUN) && !cs_rise;

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (tx_push),
        .wr_data (tx_data),
        .pop     (frame_end),
        .rd_data (tx_head),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (frame_end),
        .wr_data (capture_reg),
        .pop     (rx_pop),
        .rd_data (rx_data),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and single-cycle frame start/end events.
    always_comb begin
        next_state  = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state)
            IDLE: begin
                if (!tx_empty && !rx_full && cs) begin
                    next_state  = START;
                    frame_start = 1'b1;
                end
            end
            START: begin
                if (!cs) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (cs_rise) begin
                    next_state = FINISH;
                    frame_end  = 1'b1;
                end
            end
            FINISH: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Frame-level registers: start strobe, held TX word, busy, cs history, capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            spi_enable  <= 1'b0;
            data_in     <= '0;
            busy        <= 1'b0;
            cs_q        <= 1'b1;
            capture_reg <= '0;
        end else begin
            spi_enable <= frame_start;
            busy       <= (next_state != IDLE);
            cs_q       <= cs;
            if (frame_start) begin
                data_in <= tx_head;
            end
            if ((state == RUN) && !cs) begin
                capture_reg <= data_out;
            end
        end
    end

    // sclk generator: toggles on each divider wrap, strobes mark the new level.
    always_ff @(posedge clk) begin
        if (reset || !sclk_run) begin
            div_cnt       <= '0;
            sclk_in       <= 1'b0;
            positive_edge <= 1'b0;
            negative_edge <= 1'b0;
        end else if (div_cnt == CNT_LAST) begin
            div_cnt       <= '0;
            sclk_in       <= !sclk_in;
            positive_edge <= !sclk_in;
            negative_edge <= sclk_in;
        end else begin
            div_cnt       <= div_cnt + CNT_W'(1);
            positive_edge <= 1'b0;
            negative_edge <= 1'b0;
        end
    end

endmodule
